video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised raster timing generator for the arcade cores. Generates pixel/line counters, blanking and sync for any native resolution, advancing on a pixel clock-enable in the core clock domain rather than on a derived pixel clock. Blanks the core's RGB, and shifts the sync position by a per-frame-latched screen-centering offset. Sits between the game core (which consumes HPOS/VPOS and supplies iRGB) and the scaler/rotation stage.

## Interface
- CW, 12: RGB bus width.
- HACT, 288: active pixels per line.
- HFP, 23: horizontal front porch, in pixels.
- HSW, 31: HSYNC width, in pixels.
- HTOT, 384: total pixels per line.
- VACT, 224: active lines per frame.
- VFP, 3: vertical front porch, in lines.
- VSW, 7: VSYNC width, in lines.
- VTOT, 263: total lines per frame.
- The counter width for both counters is 9 bits. All totals must be ≤ 512.

- MCLK  in  1: core clock.
- RESET  in  1: asynchronous, active-high reset.
- PCE  in  1: pixel clock enable. All state advances only on MCLK edges where PCE=1.
- HOFS  in  4: signed horizontal sync offset, −8..+7 pixels.
- VOFS  in  4: signed vertical sync offset, −8..+7 lines.
- iRGB  in  CW: pixel colour from the core for the current HPOS/VPOS.
- HPOS  out  9: horizontal counter, combinational from the counter register.
- VPOS  out  9: vertical counter, combinational from the counter register.
- oRGB  out  CW: blanked colour, registered.
- HBLK, VBLK  out  1 each: blanking flags, active-high, registered.
- HSYN, VSYN  out  1 each: sync outputs, active-low, registered.
- LSTART  out  1: one-MCLK pulse on the PCE cycle where hcnt wraps to 0.
- FRAME  out  1: toggles at every frame wrap.

## Operation
- **Counters.** On PCE, hcnt increments, wrapping from HTOT−1 to 0. On that wrap, vcnt increments, wrapping from VTOT−1 to 0.
- **Offset latch.** HOFS/VOFS are latched into hofs_q/vofs_q on the PCE cycle where hcnt=HTOT−1 and vcnt=VTOT−1. The latched values govern the whole following frame. Mid-frame changes to HOFS/VOFS have no effect until the next frame.
- **Horizontal sync window.**
  - Raw start: hs = HACT+HFP+hofs_q.
  - Clamp: if hs < HACT, then hs = HACT. If hs+HSW > HTOT, then hs = HTOT−HSW.
  - HSYNC is active for hcnt in [hs, hs+HSW).
- **Vertical sync window.** Same rule with VACT, VFP, VSW, VTOT and vofs_q, applied against vcnt.
- **Registered outputs.** On each PCE, evaluated from the current counter values:
  - HBLK ← (hcnt ≥ HACT).
  - VBLK ← (vcnt ≥ VACT).
  - HSYN ← ~(hcnt in the H window).
  - VSYN ← ~(vcnt in the V window).
  - oRGB ← blank ? 0 : iRGB, where blank = (hcnt ≥ HACT) | (vcnt ≥ VACT).
- **Alignment.** All registered outputs for a pixel are mutually aligned. HBLK/VBLK/oRGB never disagree.
- **FRAME** toggles on the same PCE cycle that vcnt and hcnt both wrap to 0.
- **Sign handling.** The offset arithmetic uses 11-bit signed intermediates. There is no overflow for legal parameters.

## Timing
- **Reset values** (asserted asynchronously and held while RESET=1):
  - hcnt=0, vcnt=0, hofs_q=0, vofs_q=0.
  - HBLK=1, VBLK=1, HSYN=1, VSYN=1.
  - oRGB=0, LSTART=0, FRAME=0.
- **Release from reset.** The first PCE after release evaluates pixel (0,0). If reset is asserted mid-frame, the counters restart at (0,0) on release; no partial-frame state survives.
- **Latency.** Registered outputs lag HPOS/VPOS by exactly one PCE. The core has one pixel period to produce iRGB for the presented HPOS/VPOS.
- **PCE gating.** With PCE=0, every register holds and LSTART=0. PCE may have any duty cycle, including PCE=1 on every cycle.
- **Frame length.** One frame is HTOT×VTOT PCE cycles. With the defaults, that is 384×263 = 100992.
- **Coincident events.** When the line wrap, frame wrap, offset latch and FRAME toggle coincide, all take effect on the same edge. LSTART pulses on that edge too.

## Test plan
- **Defaults, HOFS=VOFS=0, PCE every 4th cycle.** Required response:
  - HSYN low for hcnt 311..341.
  - VSYN low for vcnt 227..233.
  - FRAME period 100992 PCE; LSTART period 384 PCE.
  - oRGB=0 whenever HBLK|VBLK.
- **iRGB=12'hABC held constant.** Required response: oRGB=12'hABC for exactly 288×224 PCE per frame, and 0 otherwise.
- **HOFS=+5 applied mid-frame.** Required response: the current frame keeps HSYN at 311..341; the next frame moves it to 316..346.
- **VOFS=−8 (clamp).** Raw V start is 224+3−8=219, which is clamped to 224. Required response: VSYN low for vcnt 224..230. Likewise HOFS=+7 with HFP=HTOT−HACT−HSW must clamp the H start to HTOT−HSW.
- **RESET pulsed at hcnt=100, vcnt=50, between MCLK edges.** Required response: outputs immediately take their reset values; after release, HPOS=VPOS=0 and the first full frame is 100992 PCE.
- **PCE held low for 1000 MCLK.** Required response: all outputs and HPOS/VPOS are unchanged, and LSTART stays 0.

Source files
------------

// File: rtl/video_timing_gen_if.sv
// Pixel-side bundle of the raster timing generator. Its inputs are the pixel enable, the
// centering offsets and the core colour. Its outputs are the counters, blanking, sync and markers.
interface video_timing_gen_if #(
  parameter int CW = 12
);
  logic          pce;
  logic [3:0]    hofs;
  logic [3:0]    vofs;
  logic [CW-1:0] irgb;
  logic [8:0]    hpos;
  logic [8:0]    vpos;
  logic [CW-1:0] orgb;
  logic          hblk;
  logic          vblk;
  logic          hsyn;
  logic          vsyn;
  logic          lstart;
  logic          frame;

  modport master (
    input  pce, hofs, vofs, irgb,
    output hpos, vpos, orgb, hblk, vblk, hsyn, vsyn, lstart, frame
  );

  modport slave (
    output pce, hofs, vofs, irgb,
    input  hpos, vpos, orgb, hblk, vblk, hsyn, vsyn, lstart, frame
  );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator that advances on a pixel clock enable in the core clock domain.
// Sync position follows a centering offset that is latched once per frame, and RGB is blanked outside the active area.
module video_timing_gen #(
  parameter int CW   = 12,
  parameter int HACT = 288,
  parameter int HFP  = 23,
  parameter int HSW  = 31,
  parameter int HTOT = 384,
  parameter int VACT = 224,
  parameter int VFP  = 3,
  parameter int VSW  = 7,
  parameter int VTOT = 263
) (
  input logic              mclk,
  input logic              reset,
  video_timing_gen_if.master bus
);

  localparam logic signed [10:0] H_BASE = 11'(HACT + HFP);
  localparam logic signed [10:0] H_MIN  = 11'(HACT);
  localparam logic signed [10:0] H_MAX  = 11'(HTOT - HSW);
  localparam logic signed [10:0] H_W    = 11'(HSW);
  localparam logic signed [10:0] H_TOT  = 11'(HTOT);
  localparam logic signed [10:0] V_BASE = 11'(VACT + VFP);
  localparam logic signed [10:0] V_MIN  = 11'(VACT);
  localparam logic signed [10:0] V_MAX  = 11'(VTOT - VSW);
  localparam logic signed [10:0] V_W    = 11'(VSW);
  localparam logic signed [10:0] V_TOT  = 11'(VTOT);

  logic [8:0]        hcnt;
  logic [8:0]        vcnt;
  logic [3:0]        hofs_q;
  logic [3:0]        vofs_q;
  logic signed [10:0] hs;
  logic signed [10:0] vs;
  logic signed [10:0] hcnt_s;
  logic signed [10:0] vcnt_s;
  logic              h_wrap;
  logic              v_wrap;
  logic              h_sync;
  logic              v_sync;
  logic              h_blank;
  logic              v_blank;

  logic [CW-1:0]     orgb_q;
  logic              hblk_q;
  logic              vblk_q;
  logic              hsyn_q;
  logic              vsyn_q;
  logic              lstart_q;
  logic              frame_q;

  // Sync start = nominal position + signed offset, clamped so the pulse stays inside blanking.
  always_comb begin
    hs = H_BASE + $signed({{7{hofs_q[3]}}, hofs_q});
    if (hs < H_MIN) hs = H_MIN;
    if (hs + H_W > H_TOT) hs = H_MAX;
    vs = V_BASE + $signed({{7{vofs_q[3]}}, vofs_q});
    if (vs < V_MIN) vs = V_MIN;
    if (vs + V_W > V_TOT) vs = V_MAX;
  end

  assign hcnt_s  = $signed({2'b00, hcnt});
  assign vcnt_s  = $signed({2'b00, vcnt});
  assign h_sync  = (hcnt_s >= hs) && (hcnt_s < hs + H_W);
  assign v_sync  = (vcnt_s >= vs) && (vcnt_s < vs + V_W);
  assign h_blank = (hcnt >= 9'(HACT));
  assign v_blank = (vcnt >= 9'(VACT));
  assign h_wrap  = (hcnt == 9'(HTOT - 1));
  assign v_wrap  = (vcnt == 9'(VTOT - 1));

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      hcnt     <= '0;
      vcnt     <= '0;
      hofs_q   <= '0;
      vofs_q   <= '0;
      orgb_q   <= '0;
      hblk_q   <= 1'b1;
      vblk_q   <= 1'b1;
      hsyn_q   <= 1'b1;
      vsyn_q   <= 1'b1;
      lstart_q <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      lstart_q <= 1'b0;
      if (bus.pce) begin
        hblk_q   <= h_blank;
        vblk_q   <= v_blank;
        hsyn_q   <= ~h_sync;
        vsyn_q   <= ~v_sync;
        orgb_q   <= (h_blank || v_blank) ? '0 : bus.irgb;
        lstart_q <= h_wrap;
        if (h_wrap) begin
          hcnt <= '0;
          if (v_wrap) begin
            vcnt    <= '0;
            frame_q <= ~frame_q;
            hofs_q  <= bus.hofs;
            vofs_q  <= bus.vofs;
          end else begin
            vcnt <= vcnt + 9'd1;
          end
        end else begin
          hcnt <= hcnt + 9'd1;
        end
      end
    end
  end

  assign bus.hpos   = hcnt;
  assign bus.vpos   = vcnt;
  assign bus.orgb   = orgb_q;
  assign bus.hblk   = hblk_q;
  assign bus.vblk   = vblk_q;
  assign bus.hsyn   = hsyn_q;
  assign bus.vsyn   = vsyn_q;
  assign bus.lstart = lstart_q;
  assign bus.frame  = frame_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a reduced raster, with a reference model that feeds a scoreboard.
module tb_video_timing_gen;
  localparam int CW   = 12;
  localparam int HACT = 16;
  localparam int HFP  = 2;
  localparam int HSW  = 4;
  localparam int HTOT = 28;
  localparam int VACT = 10;
  localparam int VFP  = 2;
  localparam int VSW  = 3;
  localparam int VTOT = 18;
  localparam int FRAME_PCE = HTOT * VTOT;

  typedef struct {
    logic          hblk;
    logic          vblk;
    logic          hsyn;
    logic          vsyn;
    logic          lstart;
    logic          frame;
    logic [CW-1:0] orgb;
  } exp_t;

  logic mclk = 1'b0;
  logic reset;
  always #5 mclk = ~mclk;

  video_timing_gen_if #(.CW(CW)) bus();

  video_timing_gen #(
    .CW(CW), .HACT(HACT), .HFP(HFP), .HSW(HSW), .HTOT(HTOT),
    .VACT(VACT), .VFP(VFP), .VSW(VSW), .VTOT(VTOT)
  ) dut (
    .mclk (mclk),
    .reset(reset),
    .bus  (bus.master)
  );

  int   passed = 0;
  int   total  = 0;
  exp_t sbq[$];
  exp_t last_e;
  int   hm, vm, hofs_m, vofs_m;
  logic frame_m;
  int   pce_cnt, last_lstart, first_frame_pce, abc_cnt, hs_seen, vs_seen;
  logic prev_hsyn, prev_vsyn, prev_frame;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit in_win(input int act, input int fp, input int sw, input int tot,
                                input int ofs, input int cnt);
    int s;
    s = act + fp + ofs;
    if (s < act) s = act;
    if (s + sw > tot) s = tot - sw;
    return (cnt >= s) && (cnt < s + sw);
  endfunction

  task automatic model_reset();
    hm = 0; vm = 0; hofs_m = 0; vofs_m = 0; frame_m = 1'b0;
    last_e = '{hblk: 1'b1, vblk: 1'b1, hsyn: 1'b1, vsyn: 1'b1, lstart: 1'b0, frame: 1'b0, orgb: '0};
    sbq.delete();
    pce_cnt = 0; last_lstart = -1; first_frame_pce = -1;
    prev_hsyn = 1'b1; prev_vsyn = 1'b1; prev_frame = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_hblk"}, 32'(bus.hblk), 1);
    chk({tag, "_vblk"}, 32'(bus.vblk), 1);
    chk({tag, "_hsyn"}, 32'(bus.hsyn), 1);
    chk({tag, "_vsyn"}, 32'(bus.vsyn), 1);
    chk({tag, "_orgb"}, 32'(bus.orgb), 0);
    chk({tag, "_lstart"}, 32'(bus.lstart), 0);
    chk({tag, "_frame"}, 32'(bus.frame), 0);
    chk({tag, "_hpos"}, 32'(bus.hpos), 0);
    chk({tag, "_vpos"}, 32'(bus.vpos), 0);
  endtask

  // One MCLK cycle; when p=1 the model evaluates the presented pixel and queues its outputs.
  task automatic step(input bit p, input logic [CW-1:0] rgb);
    exp_t e;
    int   eval_h, eval_v;
    bit   blank;
    @(negedge mclk);
    bus.pce  = p;
    bus.irgb = rgb;
    eval_h = hm;
    eval_v = vm;
    if (p) begin
      blank    = (hm >= HACT) || (vm >= VACT);
      e.hblk   = (hm >= HACT);
      e.vblk   = (vm >= VACT);
      e.hsyn   = !in_win(HACT, HFP, HSW, HTOT, hofs_m, hm);
      e.vsyn   = !in_win(VACT, VFP, VSW, VTOT, vofs_m, vm);
      e.orgb   = blank ? '0 : rgb;
      e.lstart = (hm == HTOT - 1);
      if (hm == HTOT - 1 && vm == VTOT - 1) begin
        frame_m = ~frame_m;
        hofs_m  = int'($signed(bus.hofs));
        vofs_m  = int'($signed(bus.vofs));
      end
      e.frame = frame_m;
      if (hm == HTOT - 1) begin
        hm = 0;
        vm = (vm == VTOT - 1) ? 0 : vm + 1;
      end else begin
        hm = hm + 1;
      end
      sbq.push_back(e);
    end
    @(posedge mclk);
    #1;
    if (p) begin
      e = sbq.pop_front();
      last_e = e;
      pce_cnt++;
    end else begin
      e = last_e;
      e.lstart = 1'b0;
    end
    chk("hblk", 32'(bus.hblk), 32'(e.hblk));
    chk("vblk", 32'(bus.vblk), 32'(e.vblk));
    chk("hsyn", 32'(bus.hsyn), 32'(e.hsyn));
    chk("vsyn", 32'(bus.vsyn), 32'(e.vsyn));
    chk("orgb", 32'(bus.orgb), 32'(e.orgb));
    chk("lstart", 32'(bus.lstart), 32'(e.lstart));
    chk("frame", 32'(bus.frame), 32'(e.frame));
    chk("hpos", 32'(bus.hpos), 32'(hm));
    chk("vpos", 32'(bus.vpos), 32'(vm));
    if (p) begin
      if (bus.lstart === 1'b1) begin
        if (last_lstart >= 0) chk("lstart_period", 32'(pce_cnt - last_lstart), HTOT);
        last_lstart = pce_cnt;
      end
      if (bus.orgb === 12'habc) abc_cnt++;
      if (bus.hsyn === 1'b0 && prev_hsyn === 1'b1) hs_seen = eval_h;
      if (bus.vsyn === 1'b0 && prev_vsyn === 1'b1) vs_seen = eval_v;
      if (bus.frame !== prev_frame && first_frame_pce < 0) first_frame_pce = pce_cnt;
      prev_hsyn  = bus.hsyn;
      prev_vsyn  = bus.vsyn;
      prev_frame = bus.frame;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.pce = 1'b0; bus.hofs = 4'd0; bus.vofs = 4'd0; bus.irgb = '0;
    model_reset();
    hs_seen = -1; vs_seen = -1; abc_cnt = 0;
    repeat (3) @(posedge mclk);
    #1 chk_reset("por");
    @(negedge mclk) reset = 1'b0;

    // Default offsets, PCE every 4th cycle, constant colour
    for (int i = 0; i < FRAME_PCE * 4; i++) step(i % 4 == 3, 12'habc);
    chk("first_frame_len", 32'(first_frame_pce), FRAME_PCE);
    chk("abc_pixels", 32'(abc_cnt), HACT * VACT);
    chk("hs_default", 32'(hs_seen), HACT + HFP);
    chk("vs_default", 32'(vs_seen), VACT + VFP);

    // Mid-frame HOFS change only takes effect from the next frame
    for (int i = 0; i < 250; i++) step(1'b1, CW'($urandom));
    bus.hofs = 4'd5;
    for (int i = 0; i < FRAME_PCE - 250; i++) step(1'b1, CW'($urandom));
    chk("hs_before_latch", 32'(hs_seen), HACT + HFP);
    for (int i = 0; i < FRAME_PCE; i++) step(1'b1, CW'($urandom));
    chk("hs_plus5", 32'(hs_seen), HACT + HFP + 5);

    // Clamp on both ends: +7 overruns HTOT, -8 underruns VACT
    bus.hofs = 4'd7;
    bus.vofs = 4'h8;
    for (int i = 0; i < FRAME_PCE; i++) step(1'b1, CW'($urandom));
    for (int i = 0; i < FRAME_PCE; i++) step(1'b1, CW'($urandom));
    chk("hs_clamp_hi", 32'(hs_seen), HTOT - HSW);
    chk("vs_clamp_lo", 32'(vs_seen), VACT);

    // PCE held low: everything holds, LSTART stays low
    for (int i = 0; i < 37; i++) step(1'b1, CW'($urandom));
    for (int i = 0; i < 1000; i++) step(1'b0, CW'($urandom));

    // Asynchronous reset mid-frame, between MCLK edges
    bus.hofs = 4'd5;
    bus.vofs = 4'd0;
    for (int k = 0; k < 2 * FRAME_PCE && !(hm == 10 && vm == 5); k++) step(1'b1, CW'($urandom));
    chk("mid_hpos", 32'(bus.hpos), 10);
    chk("mid_vpos", 32'(bus.vpos), 5);
    @(negedge mclk);
    bus.pce = 1'b1;
    #2 reset = 1'b1;
    #1 chk_reset("mid_reset");
    @(posedge mclk);
    #1 chk_reset("mid_reset_hold");
    @(negedge mclk);
    reset = 1'b0;
    bus.pce = 1'b0;
    model_reset();
    hs_seen = -1;
    for (int i = 0; i < FRAME_PCE; i++) step(1'b1, CW'($urandom));
    chk("post_reset_frame_len", 32'(first_frame_pce), FRAME_PCE);
    chk("post_reset_hs", 32'(hs_seen), HACT + HFP);
    for (int i = 0; i < HTOT; i++) step(1'b1, CW'($urandom));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
